// File: rtl/block_pkg.sv
// Shared types for the block pipeline: block width, lane-packed block type and
// the assembler state encoding.
package block_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int CNT_W       = $clog2(BLOCK_BYTES + 1);
    localparam int LANE_W      = $clog2(BLOCK_BYTES);

    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;

    // Lane 0 is the first byte of the stream.
    typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } asm_state_t;

    function automatic block_t pad_block(input logic [7:0] pad);
        block_t b;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            b[i] = pad;
        end
        return b;
    endfunction

endpackage

// File: rtl/assemble_block.sv
// Packs a valid/ready byte stream into BLOCK_BYTES-wide blocks, lane k = byte k.
// Latency: block valid the cycle after the last accept or the flush edge.
// Backpressure: ready_out drops while a block is held; held until block_ready_in.
module assemble_block
    import block_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start,
    input  logic [7:0]       data_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             flush_in,
    output block_t           block_out,
    output logic             block_valid_out,
    input  logic             block_ready_in,
    output logic [CNT_W-1:0] byte_count_out
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

    asm_state_t       state;
    logic [CNT_W-1:0] count;
    block_t           buf_q;
    logic             accept;
    logic [CNT_W-1:0] count_next;

    assign accept     = valid_in && (state == FILL);
    assign count_next = accept ? count + CNT_W'(1) : count;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            count <= '0;
            buf_q <= pad_block(PAD_BYTE);
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        count <= '0;
                        buf_q <= pad_block(PAD_BYTE);
                    end
                end
                FILL: begin
                    if (accept) begin
                        buf_q[count[LANE_W-1:0]] <= data_in;
                        count                    <= count_next;
                    end
                    // A filling byte wins over a coincident flush; both land in HOLD.
                    if (accept && (count == LAST_IDX)) begin
                        state <= HOLD;
                    end else if (flush_in) begin
                        state <= (count_next == '0) ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    if (block_ready_in) begin
                        state <= FILL;
                        count <= '0;
                        buf_q <= pad_block(PAD_BYTE);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                    buf_q <= pad_block(PAD_BYTE);
                end
            endcase
        end
    end

    // Handshake outputs come straight off the state register.
    assign ready_out       = (state == FILL);
    assign block_valid_out = (state == HOLD);
    assign block_out       = buf_q;
    assign byte_count_out  = count;

endmodule

// File: doc/assemble_block.md
# assemble_block

Byte-to-block assembler: accepts a stream of bytes over a valid/ready handshake and packs them into a 16-byte block presented on a wide output with its own valid/ready handshake. It is the receive-side counterpart of the block-to-byte streamer in the block pipeline. Byte k of a block lands in lane k, so a block streamed out lane 0 first is rebuilt unchanged. A flush pads a partial block so trailing data is never lost.

## Interface
- BLOCK_BYTES, 16: bytes per block; byte count width is $clog2(BLOCK_BYTES+1).
- PAD_BYTE, 8'h00: value written to every lane not filled by input data.

Ports (clock and reset first):
- clk_in  input  1  system clock; all logic on posedge.
- rst_in  input  1  reset, synchronous and active-high.
- start  input  1  arm the assembler. Honoured only in IDLE.
- data_in  input  8  incoming byte.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  byte accepted on an edge where valid_in && ready_out.
- flush_in  input  1  close the current partial block. Honoured only in FILL.
- block_out  output  [BLOCK_BYTES-1:0][7:0]  assembled block; lane 0 holds the first byte.
- block_valid_out  output  1  block_out is complete and stable.
- block_ready_in  input  1  consumer takes the block on an edge where block_valid_out && block_ready_in.
- byte_count_out  output  5  real (non-pad) bytes written into the current block.

## Operation
- Reset values: state IDLE, ready_out=0, block_valid_out=0, byte_count_out=0, all block_out lanes = PAD_BYTE.
- IDLE:
  - ready_out=0.
  - On start: go to FILL, count=0, all lanes = PAD_BYTE.
- FILL:
  - ready_out=1.
  - Accept: lane[count] <= data_in and count <= count+1.
  - If the accepted byte makes count == BLOCK_BYTES, go to HOLD.
- FILL with flush_in:
  - count>0: go to HOLD. Unwritten lanes stay PAD_BYTE.
  - count==0: go to IDLE. No block is produced.
  - flush_in together with an accepted byte: the byte is written first, then the flush applies to the new count. If that byte fills the block, the result is plain HOLD.
- HOLD:
  - block_valid_out=1, ready_out=0. block_out and byte_count_out are frozen.
  - On block_ready_in: go to FILL, count=0, all lanes = PAD_BYTE (auto re-arm for back-to-back blocks).
- start outside IDLE and flush_in outside FILL are ignored.
- Output decode: ready_out and block_valid_out are decoded from the state register only, with no combinational path from inputs. block_out is the register buffer itself.

## Timing
- Byte acceptance takes effect at the accepting edge, one byte per cycle maximum.
- Full-rate fill takes 16 accepting edges. block_valid_out rises the cycle after the 16th accept.
- Flush latency: block_valid_out rises the cycle after the edge where flush_in is sampled in FILL.
- Block handoff completes at the edge with block_valid_out && block_ready_in. On the next cycle ready_out=1 and byte_count_out=0.
- Minimum period per full block is 17 cycles (16 fill plus 1 handoff).
- A byte offered in HOLD or IDLE is not accepted and must be held by the producer.
- Reset mid-operation: on the next cycle all outputs return to their reset values. A partial block is discarded and start is required again.
- Count never exceeds BLOCK_BYTES. There is no wrap-around, because reaching BLOCK_BYTES forces HOLD.

## Structure
- Shared package block_pkg:
  - BLOCK_BYTES constant.
  - typedef block_t = logic [BLOCK_BYTES-1:0][7:0], shared with the block-to-byte streamer.
  - enum asm_state_t {IDLE, FILL, HOLD}.
- Single module with no sub-module. The lane write is an indexed register update and the FSM is three states.

## Test plan
- Full block: reset, start, then 0x00..0x0F on consecutive cycles with block_ready_in=0.
  - Cycle after the 16th accept: block_valid_out=1, block_out[i]=i, byte_count_out=16, ready_out=0.
- Backpressure: in HOLD, keep block_ready_in=0 for 5 cycles while valid_in=1 with 0xEE.
  - block_out is unchanged and 0xEE is never accepted.
  - Raise block_ready_in: next cycle ready_out=1, byte_count_out=0, all lanes 0x00.
- Flush with pad: start, bytes 0xA0..0xA4, then flush_in.
  - Next cycle: block_valid_out=1, lanes 0..4 = A0..A4, lanes 5..15 = 0x00, byte_count_out=5.
- Simultaneous accept and flush: at count 3, assert valid_in with 0xFF and flush_in together.
  - Lane 3 = 0xFF, byte_count_out=4, block_valid_out=1 next cycle.
- Empty flush and ignored controls: flush_in in FILL at count 0.
  - Next cycle IDLE: ready_out=0 and block_valid_out never rises.
  - start asserted in HOLD has no effect.
- Reset mid-fill: assert rst_in at count 7.
  - Next cycle: ready_out=0, byte_count_out=0, all lanes 0x00.
  - Bytes are ignored until start.
